// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-field width helpers for the
// direct-mapped data cache.
//   state_t      : controller state encoding
//   off_bits     : byte-offset field width for a given word width
//   word_bits    : word-in-line field width
//   index_bits   : line-index field width
//   tag_bits     : remaining upper address bits
package dcache_pkg;

    localparam int STATS_W = 32;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REFILL_REQ  = 3'd1,
        REFILL_WAIT = 3'd2,
        WRITE       = 3'd3,
        RESP        = 3'd4
    } state_t;

    function automatic int off_bits(input int width);
        return $clog2(width / 8);
    endfunction

    function automatic int word_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_w, input int width,
                                    input int lines, input int words_per_line);
        return addr_w - off_bits(width) - word_bits(words_per_line) - index_bits(lines);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU-side and memory-side handshake bundle for dcache_dm.
//   slave  : the cache (accepts CPU requests, issues memory requests)
//   master : the environment (issues CPU requests, serves memory requests)
// CPU side : cpu_req_valid/ready, cpu_we, cpu_be, cpu_addr, cpu_wdata,
//            cpu_resp_valid, cpu_rdata
// Mem side : mem_req_valid/ready, mem_we, mem_be, mem_addr, mem_wdata,
//            mem_resp_valid, mem_rdata
interface dcache_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic                 cpu_req_valid;
    logic                 cpu_req_ready;
    logic                 cpu_we;
    logic [WIDTH/8-1:0]   cpu_be;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [WIDTH-1:0]     cpu_wdata;
    logic                 cpu_resp_valid;
    logic [WIDTH-1:0]     cpu_rdata;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_we;
    logic [WIDTH/8-1:0]   mem_be;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WIDTH-1:0]     mem_wdata;
    logic                 mem_resp_valid;
    logic [WIDTH-1:0]     mem_rdata;

    modport slave (
        input  cpu_req_valid, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_rdata,
        output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req_valid, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
        input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_data_ram.sv
// dcache_data_ram: cache data array, DEPTH words of WIDTH bits.
//   clk            : write clock
//   we, be         : write enable and per-byte enables
//   waddr, wdata   : write port
//   raddr, rdata   : asynchronous read port
// Contents are not reset.
module dcache_data_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [WIDTH/8-1:0]   be,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [AW-1:0]        raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : dcache_if.slave (CPU request/response, memory request/response)
//   hit_count,
//   miss_count   : accepted-load hit/miss counters, saturating; present only
//                  when DCACHE_STATS_EN is defined
// Load misses refill the whole line one beat at a time; stores always go to
// memory and merge into the line only when it already holds the address.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | ready for a request; load hits answered from here
//   REFILL_REQ  | issuing refill read for the current beat
//   REFILL_WAIT | waiting for refill data of the current beat
//   WRITE       | issuing the write-through store to memory
//   RESP        | refill done; load word captured into the response register
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int ADDR_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    dcache_if.slave         bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [STATS_W-1:0] hit_count,
    output logic [STATS_W-1:0] miss_count
`endif
);

    localparam int BE_W  = WIDTH / 8;
    localparam int OFF_W = off_bits(WIDTH);
    localparam int WRD_W = word_bits(WORDS_PER_LINE);
    localparam int IDX_W = index_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_W, WIDTH, LINES, WORDS_PER_LINE);
    localparam int RA_W  = IDX_W + WRD_W;
    localparam int WA_W  = ADDR_W - OFF_W;
    localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS_PER_LINE - 1);

    state_t state, state_n;

    logic [LINES-1:0]  valid_bits;
    logic [TAG_W-1:0]  tag_arr [LINES];

    logic [WA_W-1:0]   waddr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [WRD_W-1:0]  beat;
    logic              resp_valid_q;
    logic [WIDTH-1:0]  rdata_q;

    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [RA_W-1:0]   ram_waddr;
    logic [WIDTH-1:0]  ram_wdata;
    logic [RA_W-1:0]   ram_raddr;
    logic [WIDTH-1:0]  ram_rdata;

    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [WRD_W-1:0]  cpu_word;
    logic [TAG_W-1:0]  q_tag;
    logic [IDX_W-1:0]  q_idx;
    logic [WRD_W-1:0]  q_word;
    logic              hit;
    logic              accept;
    logic              last_fill;
    logic              unused_ok;

    assign cpu_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign cpu_idx  = bus.cpu_addr[OFF_W+WRD_W +: IDX_W];
    assign cpu_word = bus.cpu_addr[OFF_W +: WRD_W];
    assign q_tag    = waddr_q[WA_W-1 -: TAG_W];
    assign q_idx    = waddr_q[WRD_W +: IDX_W];
    assign q_word   = waddr_q[WRD_W-1:0];

    // Byte-offset bits never select anything: accesses are whole words.
    assign unused_ok = ^bus.cpu_addr[OFF_W-1:0];

    assign hit       = valid_bits[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
    assign accept    = (state == IDLE) && bus.cpu_req_valid;
    assign last_fill = (state == REFILL_WAIT) && bus.mem_resp_valid && (beat == LAST_BEAT);

    assign bus.cpu_resp_valid = resp_valid_q;
    assign bus.cpu_rdata      = rdata_q;

    dcache_data_ram #(
        .WIDTH (WIDTH),
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (RA_W)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n           = state;
        bus.cpu_req_ready = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_be        = '0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        ram_we            = 1'b0;
        ram_be            = '0;
        ram_waddr         = {cpu_idx, cpu_word};
        ram_wdata         = bus.cpu_wdata;
        ram_raddr         = {cpu_idx, cpu_word};

        case (state)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) begin
                    if (bus.cpu_we) begin
                        state_n = WRITE;
                        if (hit) begin
                            ram_we = 1'b1;
                            ram_be = bus.cpu_be;
                        end
                    end else if (!hit) begin
                        state_n = REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_be        = '1;
                bus.mem_addr      = {q_tag, q_idx, beat, {OFF_W{1'b0}}};
                if (bus.mem_req_ready) begin
                    state_n = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                ram_waddr = {q_idx, beat};
                ram_wdata = bus.mem_rdata;
                ram_be    = '1;
                if (bus.mem_resp_valid) begin
                    ram_we  = 1'b1;
                    state_n = (beat == LAST_BEAT) ? RESP : REFILL_REQ;
                end
            end
            WRITE: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_we        = 1'b1;
                bus.mem_be        = be_q;
                bus.mem_addr      = {waddr_q, {OFF_W{1'b0}}};
                bus.mem_wdata     = wdata_q;
                if (bus.mem_req_ready) begin
                    state_n = IDLE;
                end
            end
            RESP: begin
                ram_raddr = {q_idx, q_word};
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits   <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            beat         <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (accept) begin
                waddr_q <= bus.cpu_addr[ADDR_W-1:OFF_W];
                wdata_q <= bus.cpu_wdata;
                be_q    <= bus.cpu_be;
                beat    <= '0;
                if (!bus.cpu_we) begin
                    if (hit) begin
                        resp_valid_q <= 1'b1;
                        rdata_q      <= ram_rdata;
                    end else begin
                        // Refill overwrites the line word by word, so the old
                        // contents stop being valid before the first beat lands.
                        valid_bits[cpu_idx] <= 1'b0;
                    end
                end
            end
            if (state == REFILL_WAIT && bus.mem_resp_valid) begin
                if (beat == LAST_BEAT) begin
                    valid_bits[q_idx] <= 1'b1;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
            if (state == RESP) begin
                resp_valid_q <= 1'b1;
                rdata_q      <= ram_rdata;
            end
            if (state == WRITE && bus.mem_req_ready) begin
                resp_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (last_fill) begin
            tag_arr[q_idx] <= q_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept && !bus.cpu_we) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
module tb_dcache_dm;

    logic clk;
    logic rst_n;

    dcache_if #(.WIDTH(32), .ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_dm #(
        .WIDTH(32), .ADDR_W(32), .LINES(16), .WORDS_PER_LINE(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    // memory-side log
    logic [31:0] rd_addr [0:31];
    int          rd_n;
    int          wr_n;
    int          resp_n;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    int          stall;
    logic        pend;
    logic [31:0] pend_addr;

    function automatic logic [31:0] model(input logic [31:0] a);
        return 32'hA5A5_0000 | {16'h0, a[15:0]};
    endfunction

    // Backing memory: zero-wait by default, data one cycle after read accept.
    initial begin
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        pend = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
                bus.mem_req_ready = 1'b1;
            end else begin
                if (pend) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = model(pend_addr);
                    resp_n++;
                    pend = 1'b0;
                end
                if (bus.mem_req_valid && stall > 0) begin
                    bus.mem_req_ready = 1'b0;
                    stall--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                end
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    if (bus.mem_we) begin
                        wr_n++;
                        wr_addr = bus.mem_addr;
                        wr_data = bus.mem_wdata;
                        wr_be   = bus.mem_be;
                    end else begin
                        if (rd_n < 32) rd_addr[rd_n] = bus.mem_addr;
                        rd_n++;
                        pend      = 1'b1;
                        pend_addr = bus.mem_addr;
                    end
                end
            end
        end
    end

    task automatic clear_log();
        rd_n   = 0;
        wr_n   = 0;
        resp_n = 0;
    endtask

    task automatic cpu_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_we        = we;
        bus.cpu_be        = be;
        bus.cpu_addr      = addr;
        bus.cpu_wdata     = wdata;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        lat = 1;
        while (!bus.cpu_resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.cpu_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", bus.cpu_req_ready);
        end
        checks++;
        if ({bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_we} !== 3'b000) begin
            errors++; $display("FAIL reset_valids: got %b expected 000",
                               {bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_we});
        end
        checks++;
        if ({bus.cpu_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 100'h0) begin
            errors++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%h expected 0",
                               bus.cpu_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if ({hit_count, miss_count} !== 64'h0) begin
            errors++; $display("FAIL reset_stats: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_cold_load();
        logic [31:0] rd;
        int lat;
        clear_log();
        cpu_op(1'b0, 4'h0, 32'h104, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_0104) begin
            errors++; $display("FAIL cold_data: got %h expected a5a50104", rd);
        end
        checks++;
        if (lat !== 10) begin
            errors++; $display("FAIL cold_latency: got %0d expected 10", lat);
        end
        checks++;
        if (rd_n !== 4) begin
            errors++; $display("FAIL cold_reads: got %0d expected 4", rd_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_addr[i] !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL cold_addr%0d: got %h expected %h", i, rd_addr[i], 32'h100 + 32'(4 * i));
            end
        end
        cpu_op(1'b0, 4'h0, 32'h108, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_0108) begin
            errors++; $display("FAIL hit_data: got %h expected a5a50108", rd);
        end
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL hit_latency: got %0d expected 1", lat);
        end
        checks++;
        if (rd_n !== 4) begin
            errors++; $display("FAIL hit_no_traffic: got %0d reads expected 4", rd_n);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++; $display("FAIL stats: got hit=%0d miss=%0d expected 1 1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_store_hit();
        logic [31:0] rd;
        int lat;
        clear_log();
        stall = 2;
        cpu_op(1'b1, 4'b0011, 32'h104, 32'hDEAD_BEEF, rd, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL store_latency: got %0d expected 4", lat);
        end
        checks++;
        if (wr_n !== 1 || rd_n !== 0) begin
            errors++; $display("FAIL store_traffic: got writes=%0d reads=%0d expected 1 0", wr_n, rd_n);
        end
        checks++;
        if ({wr_addr, wr_data, wr_be} !== {32'h104, 32'hDEAD_BEEF, 4'b0011}) begin
            errors++; $display("FAIL store_fields: got addr=%h data=%h be=%b expected 104 deadbeef 0011",
                               wr_addr, wr_data, wr_be);
        end
        cpu_op(1'b0, 4'h0, 32'h104, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_BEEF) begin
            errors++; $display("FAIL store_merge: got %h expected a5a5beef", rd);
        end
        checks++;
        if (lat !== 1 || rd_n !== 0) begin
            errors++; $display("FAIL store_merge_hit: got lat=%0d reads=%0d expected 1 0", lat, rd_n);
        end
    endtask

    task automatic test_evict();
        logic [31:0] rd;
        int lat;
        clear_log();
        cpu_op(1'b0, 4'h0, 32'h204, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_0204 || lat !== 10) begin
            errors++; $display("FAIL evict_load: got %h lat=%0d expected a5a50204 10", rd, lat);
        end
        checks++;
        if (rd_n !== 4 || rd_addr[0] !== 32'h200 || rd_addr[3] !== 32'h20C) begin
            errors++; $display("FAIL evict_reads: got n=%0d first=%h last=%h expected 4 200 20c",
                               rd_n, rd_addr[0], rd_addr[3]);
        end
        cpu_op(1'b0, 4'h0, 32'h104, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_0104 || rd_n !== 8) begin
            errors++; $display("FAIL evict_reload: got %h reads=%0d expected a5a50104 8", rd, rd_n);
        end
    endtask

    task automatic test_store_miss();
        logic [31:0] rd;
        int lat;
        clear_log();
        cpu_op(1'b1, 4'b1111, 32'h300, 32'h1234_5678, rd, lat);
        checks++;
        if (wr_n !== 1 || rd_n !== 0 || lat !== 2) begin
            errors++; $display("FAIL store_miss: got writes=%0d reads=%0d lat=%0d expected 1 0 2", wr_n, rd_n, lat);
        end
        checks++;
        if (wr_addr !== 32'h300 || wr_be !== 4'hF || wr_data !== 32'h1234_5678) begin
            errors++; $display("FAIL store_miss_fields: got %h %b %h expected 300 1111 12345678", wr_addr, wr_be, wr_data);
        end
        cpu_op(1'b0, 4'h0, 32'h104, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_0104 || lat !== 1) begin
            errors++; $display("FAIL no_allocate: got %h lat=%0d expected a5a50104 1", rd, lat);
        end
        cpu_op(1'b0, 4'h0, 32'h300, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_0300 || rd_n !== 4) begin
            errors++; $display("FAIL miss_after_store: got %h reads=%0d expected a5a50300 4", rd, rd_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_we        = 1'b0;
        bus.cpu_addr      = 32'h30C;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            exp = model(32'h30C - 32'(4 * (i - 1)));
            checks++;
            if (bus.cpu_resp_valid !== 1'b1 || bus.cpu_rdata !== exp) begin
                errors++; $display("FAIL b2b_%0d: got valid=%b data=%h expected 1 %h",
                                   i, bus.cpu_resp_valid, bus.cpu_rdata, exp);
            end
            if (i < 3) bus.cpu_addr = 32'h30C - 32'(4 * i);
            else bus.cpu_req_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd;
        int lat;
        int guard;
        clear_log();
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_we        = 1'b0;
        bus.cpu_addr      = 32'h104;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        guard = 0;
        while (resp_n < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (resp_n < 2) begin
            errors++; $display("FAIL midrefill_timeout: got %0d beats expected 2", resp_n);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL midrefill_drop: got mem_req_valid=%b expected 0", bus.mem_req_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cpu_req_ready !== 1'b1 || {bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_we} !== 3'b000
            || {bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.cpu_rdata} !== 100'h0) begin
            errors++; $display("FAIL midrefill_outputs: got ready=%b rv=%b mv=%b addr=%h expected 1 0 0 0",
                               bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_addr);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if ({hit_count, miss_count} !== 64'h0) begin
            errors++; $display("FAIL midrefill_stats: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
        end
`endif
        clear_log();
        cpu_op(1'b0, 4'h0, 32'h104, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5_0104 || rd_n !== 4 || lat !== 10) begin
            errors++; $display("FAIL midrefill_reload: got %h reads=%0d lat=%0d expected a5a50104 4 10", rd, rd_n, lat);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        stall  = 0;
        rd_n   = 0;
        wr_n   = 0;
        resp_n = 0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rst_n  = 1'b0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_we        = 1'b0;
        bus.cpu_be        = '0;
        bus.cpu_addr      = '0;
        bus.cpu_wdata     = '0;

        test_reset();
        test_cold_load();
        test_store_hit();
        test_evict();
        test_store_miss();
        test_back_to_back();
        test_reset_mid_refill();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Direct-mapped, write-through, no-write-allocate data cache between the datapath load/store unit and a slower word-wide backing memory. Generalised successor of the single-cycle byte-addressed data memory: parametrised width, line count and line size, per-byte write enables, and a valid/ready handshake on both sides. Read misses trigger a multi-beat line refill FSM; writes always propagate to memory and update the line only on a hit.

## Interface
- WIDTH, 32: data word width in bits (multiple of 8)
- ADDR_W, 32: byte address width
- LINES, 16: number of cache lines (power of 2)
- WORDS_PER_LINE, 4: words per line (power of 2, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  cache accepts a request this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_be  in  WIDTH/8  byte enables for stores (ignored on loads)
- cpu_addr  in  ADDR_W  byte address; low log2(WIDTH/8) bits ignored
- cpu_wdata  in  WIDTH  store data
- cpu_resp_valid  out  1  one-cycle completion pulse (loads and stores)
- cpu_rdata  out  WIDTH  load data, valid with cpu_resp_valid
- mem_req_valid  out  1  backing-memory request
- mem_req_ready  in  1  backing memory accepts request
- mem_we  out  1  memory write
- mem_be  out  WIDTH/8  memory byte enables (all ones on refill reads)
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  WIDTH  memory write data
- mem_resp_valid  in  1  read data returned
- mem_rdata  in  WIDTH  returned read data

## Operation
- Address split, LSB up: byte offset log2(WIDTH/8), word-in-line log2(WORDS_PER_LINE), index log2(LINES), tag = remainder.
- Per line: valid bit, tag, WORDS_PER_LINE data words.
- States: IDLE, REFILL_REQ, REFILL_WAIT, WRITE, RESP.
- IDLE: cpu_req_ready=1; request accepted on valid&ready, with address/data/be latched.
- Load hit: stay in IDLE; cpu_resp_valid and cpu_rdata on the next cycle.
- Load miss: go to REFILL_REQ with beat counter 0. REFILL_REQ drives a read for line base + beat*WIDTH/8 and moves to REFILL_WAIT on mem_req_ready. REFILL_WAIT writes mem_rdata into the beat slot on mem_resp_valid. After the last beat it sets valid and tag and goes to RESP; otherwise it increments beat and returns to REFILL_REQ.
- RESP: cpu_resp_valid=1 with the requested word, then back to IDLE.
- Store: on a hit, cached bytes with cpu_be=1 are merged in the accept cycle. Hit or miss, go to WRITE, which drives mem_we=1 with the latched be/addr/data. On mem_req_ready, pulse cpu_resp_valid the next cycle and return to IDLE. A store miss does not allocate.
- mem_req_valid and all mem_* fields stay stable until mem_req_ready. At most one outstanding memory transaction.
- mem_resp_valid outside REFILL_WAIT is ignored.
- cpu_resp_valid has no backpressure. cpu_req_ready=0 in every state except IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, all valid bits 0, beat 0. Outputs: cpu_req_ready=1, all other outputs 0. Data/tag arrays are not cleared.
- Reset mid-refill or mid-write abandons the transaction. The line is left invalid and mem_req_valid drops immediately.
- Load hit latency: 1 cycle.
- Load miss latency with zero-wait memory: 2·WORDS_PER_LINE + 2 cycles from accept to response.
- Store latency: 1 cycle plus memory accept wait, plus 1 cycle.
- Back-to-back load hits sustain one per cycle.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count and miss_count (32 bits each, out). They count accepted loads only, saturate at all-ones, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package dcache_pkg holds the state enum (IDLE, REFILL_REQ, REFILL_WAIT, WRITE, RESP) and localparam functions for offset/word/index/tag widths.
- One sub-module, dcache_data_ram: LINES·WORDS_PER_LINE × WIDTH array with an async read port and a byte-enable synchronous write port.
- Tags and valid bits live in flops in the top module.

## Test plan
Backing memory model: mem[a] = 0xA5A5_0000 | a[15:0]. Parameters: WIDTH=32, LINES=16, WORDS_PER_LINE=4.
- Cold load 0x104 -> mem reads 0x100, 0x104, 0x108, 0x10C in order, then response 0xA5A5_0104. A following load 0x108 responds 0xA5A5_0108 one cycle after accept with no mem traffic.
- Store 0x104, be=0011, data 0xDEAD_BEEF (hit) -> one mem write with be=0011. A following load 0x104 returns 0xA5A5_BEEF with no refill.
- Load 0x204 (same index 0, tag 2) evicts the line -> a following load 0x104 refills again with 4 reads.
- Store miss to 0x300 -> one mem write, no refill. A following load 0x300 performs a 4-beat refill.
- rst_n low after 2 refill beats -> all outputs 0 and cpu_req_ready=1 after release. Reloading 0x104 performs a full 4-beat refill.
- With DCACHE_STATS_EN, after the first two loads of scenario 1 -> hit_count=1, miss_count=1.
